// File: rtl/gameover_text_ctrl_if.sv
// Signal bundle between the game core / video timing and the game-over
// text controller. The controller uses the slave side.
interface gameover_text_ctrl_if;
  logic        game_over;
  logic        tom_won;
  logic        key_enter;
  logic        frame_start;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic [11:0] char_xy;
  logic        winner_tom;
  logic        text_en;
  logic [3:0]  char_line;
  logic [2:0]  char_px;
  logic        restart;
  logic        busy;

  modport master (
    output game_over, tom_won, key_enter, frame_start, hcount, vcount,
    input  char_xy, winner_tom, text_en, char_line, char_px, restart, busy
  );

  modport slave (
    input  game_over, tom_won, key_enter, frame_start, hcount, vcount,
    output char_xy, winner_tom, text_en, char_line, char_px, restart, busy
  );
endinterface

// File: rtl/gameover_text_ctrl.sv
// Game-over message controller: phase FSM, winner latch, Enter-key handling
// with blink while waiting, and ROM addressing aligned to the ROM's
// registered char_code.
module gameover_text_ctrl #(
  parameter int TEXT_X       = 256,
  parameter int TEXT_Y       = 300,
  parameter int CHAR_W       = 8,
  parameter int CHAR_H       = 16,
  parameter int MSG_LEN      = 32,
  parameter int BLINK_FRAMES = 30
) (
  input logic                 clk,
  input logic                 rst_n,
  gameover_text_ctrl_if.slave bus
);

  localparam int CSH = $clog2(CHAR_W);
  localparam int CW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [11:0] X_LO  = 12'(TEXT_X);
  localparam logic [11:0] X_END = 12'(TEXT_X + MSG_LEN * CHAR_W);
  localparam logic [11:0] Y_LO  = 12'(TEXT_Y);
  localparam logic [11:0] Y_END = 12'(TEXT_Y + CHAR_H);

  typedef enum logic [1:0] {PLAY, SHOW, ARMED, RESTART} state_t;

  state_t        state;
  logic          winner_q;
  logic          restart_q;
  logic          busy_q;
  logic          blink_on;
  logic [CW-1:0] blink_cnt;

  logic          key_m, key_s, key_s_d;
  logic          key_rise;

  logic [11:0]   xy_q;
  logic          en_s1, en_s2;
  logic [3:0]    line_s1, line_s2;
  logic [2:0]    px_s1, px_s2;

  logic [11:0]   hx, vy;
  logic [10:0]   dx;
  logic          in_win;

  assign key_rise = key_s & ~key_s_d;

  assign hx     = {1'b0, bus.hcount};
  assign vy     = {1'b0, bus.vcount};
  assign dx     = bus.hcount - 11'(TEXT_X);
  assign in_win = (hx >= X_LO) && (hx < X_END) && (vy >= Y_LO) && (vy < Y_END);

  // Two-flop synchroniser for the asynchronous Enter key plus edge history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_m   <= 1'b0;
      key_s   <= 1'b0;
      key_s_d <= 1'b0;
    end else begin
      key_m   <= bus.key_enter;
      key_s   <= key_m;
      key_s_d <= key_s;
    end
  end

  // Game phase FSM with winner latch, blink timer and restart pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PLAY;
      winner_q  <= 1'b0;
      restart_q <= 1'b0;
      busy_q    <= 1'b0;
      blink_on  <= 1'b1;
      blink_cnt <= '0;
    end else begin
      case (state)
        PLAY: begin
          if (bus.game_over) begin
            winner_q <= bus.tom_won;
            state    <= SHOW;
            busy_q   <= 1'b1;
          end
        end
        SHOW: begin
          // A key still held from play must be released before arming.
          if (!key_s) begin
            state     <= ARMED;
            blink_cnt <= '0;
            blink_on  <= 1'b0;
          end
        end
        ARMED: begin
          // Key edge takes priority; a coincident frame tick is dropped.
          if (key_rise) begin
            state     <= RESTART;
            restart_q <= 1'b1;
          end else if (bus.frame_start) begin
            if (blink_cnt == CW'(BLINK_FRAMES - 1)) begin
              blink_cnt <= '0;
              blink_on  <= ~blink_on;
            end else begin
              blink_cnt <= blink_cnt + CW'(1);
            end
          end
        end
        RESTART: begin
          state     <= PLAY;
          restart_q <= 1'b0;
          busy_q    <= 1'b0;
        end
        default: begin
          state     <= PLAY;
          restart_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1 ROM address and window/glyph info; stage 2 matches ROM latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xy_q    <= '0;
      en_s1   <= 1'b0;
      en_s2   <= 1'b0;
      line_s1 <= '0;
      line_s2 <= '0;
      px_s1   <= '0;
      px_s2   <= '0;
    end else begin
      xy_q    <= in_win ? {4'h0, 8'(dx >> CSH)} : 12'h0FF;
      en_s1   <= in_win && (state != PLAY) && ((state != ARMED) || blink_on);
      line_s1 <= 4'((bus.vcount - 11'(TEXT_Y)) & 11'(CHAR_H - 1));
      px_s1   <= 3'(dx & 11'(CHAR_W - 1));
      en_s2   <= en_s1;
      line_s2 <= line_s1;
      px_s2   <= px_s1;
    end
  end

  assign bus.char_xy    = xy_q;
  assign bus.winner_tom = winner_q;
  assign bus.text_en    = en_s2;
  assign bus.char_line  = line_s2;
  assign bus.char_px    = px_s2;
  assign bus.restart    = restart_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_gameover_text_ctrl.sv
// Bench for gameover_text_ctrl: directed stimulus pushes expected values
// tagged with the cycle they must appear; a negedge monitor compares them.
module tb_gameover_text_ctrl;

  logic clk;
  logic rst_n;

  gameover_text_ctrl_if bus ();

  gameover_text_ctrl #(
    .TEXT_X(256), .TEXT_Y(300), .CHAR_W(8), .CHAR_H(16),
    .MSG_LEN(32), .BLINK_FRAMES(30)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    int unsigned cyc;
    int          sel;
    logic [11:0] val;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc;
  int          checks;
  int          errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] pick(int sel);
    case (sel)
      0:       return bus.char_xy;
      1:       return {11'd0, bus.text_en};
      2:       return {8'd0, bus.char_line};
      3:       return {9'd0, bus.char_px};
      4:       return {11'd0, bus.winner_tom};
      5:       return {11'd0, bus.restart};
      default: return {11'd0, bus.busy};
    endcase
  endfunction

  // Monitor: compare every expectation due at this cycle.
  always @(negedge clk) begin
    for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        logic [11:0] got;
        got = pick(sb[i].sel);
        checks++;
        if (sb[i].cyc < cyc || got !== sb[i].val) begin
          errors++;
          $display("FAIL %s @cyc %0d: got 0x%03h expected 0x%03h",
                   sb[i].name, sb[i].cyc, got, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_at(int sel, logic [11:0] val, int unsigned lat, string name);
    exp_t e;
    e.cyc  = cyc + lat;
    e.sel  = sel;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic probe(logic [10:0] h, logic [10:0] v, logic [11:0] xy,
                       logic en, logic [3:0] line, logic [2:0] px);
    bus.hcount = h;
    bus.vcount = v;
    exp_at(0, xy, 1, "char_xy");
    exp_at(1, {11'd0, en}, 2, "text_en");
    exp_at(2, {8'd0, line}, 2, "char_line");
    exp_at(3, {9'd0, px}, 2, "char_px");
    step();
  endtask

  // Expect one restart pulse exactly 3 cycles after key_enter rises now.
  task automatic expect_restart_pulse();
    for (int unsigned k = 1; k <= 8; k++)
      exp_at(5, (k == 3) ? 12'd1 : 12'd0, k, "restart_pulse");
    exp_at(6, 12'd1, 3, "busy_in_restart");
    exp_at(6, 12'd0, 4, "busy_after_restart");
  endtask

  initial begin
    logic blink_exp;
    logic blink_prev;
    checks          = 0;
    errors          = 0;
    rst_n           = 1'b0;
    bus.game_over   = 1'b0;
    bus.tom_won     = 1'b0;
    bus.key_enter   = 1'b0;
    bus.frame_start = 1'b0;
    bus.hcount      = '0;
    bus.vcount      = '0;

    // Reset values
    step(); step();
    exp_at(0, 12'h000, 0, "rst_char_xy");
    exp_at(1, 12'd0, 0, "rst_text_en");
    exp_at(2, 12'd0, 0, "rst_char_line");
    exp_at(3, 12'd0, 0, "rst_char_px");
    exp_at(4, 12'd0, 0, "rst_winner");
    exp_at(5, 12'd0, 0, "rst_restart");
    exp_at(6, 12'd0, 0, "rst_busy");
    step();
    rst_n = 1'b1;
    step(); step();

    // Addressing in PLAY: text never enabled
    probe(11'd256, 11'd300, 12'h000, 1'b0, 4'd0, 3'd0);
    probe(11'd259, 11'd305, 12'h000, 1'b0, 4'd5, 3'd3);
    probe(11'd300, 11'd310, 12'h005, 1'b0, 4'd10, 3'd4);
    step(); step();

    // Round won by JERRY, key low: SHOW then ARMED, then restart
    bus.game_over = 1'b1;
    bus.tom_won   = 1'b0;
    exp_at(6, 12'd1, 1, "busy_show");
    exp_at(4, 12'd0, 1, "winner_jerry");
    step();
    bus.game_over = 1'b0;
    step();
    probe(11'd256, 11'd300, 12'h000, 1'b0, 4'd0, 3'd0);  // ARMED, blink off
    bus.key_enter = 1'b1;
    expect_restart_pulse();
    for (int k = 0; k < 10; k++) step();
    bus.key_enter = 1'b0;
    for (int k = 0; k < 4; k++) step();

    // Enter held as game_over arrives together with key_rise: TOM wins, stays SHOW
    bus.key_enter = 1'b1;
    step(); step();
    bus.game_over = 1'b1;
    bus.tom_won   = 1'b1;
    exp_at(4, 12'd1, 1, "winner_tom");
    exp_at(6, 12'd1, 1, "busy_held");
    for (int unsigned k = 1; k <= 12; k++) exp_at(5, 12'd0, k, "no_restart_held");
    step();
    bus.game_over = 1'b0;
    step(); step(); step();
    probe(11'd256, 11'd300, 12'h000, 1'b1, 4'd0, 3'd0);
    probe(11'd300, 11'd310, 12'h005, 1'b1, 4'd10, 3'd4);
    probe(11'd511, 11'd315, 12'h01F, 1'b1, 4'd15, 3'd7);
    probe(11'd512, 11'd315, 12'h0FF, 1'b0, 4'd15, 3'd0);
    probe(11'd511, 11'd316, 12'h0FF, 1'b0, 4'd0, 3'd7);
    probe(11'd255, 11'd300, 12'h0FF, 1'b0, 4'd0, 3'd7);
    // Second game_over during SHOW is ignored
    bus.game_over = 1'b1;
    bus.tom_won   = 1'b0;
    exp_at(4, 12'd1, 1, "winner_hold1");
    exp_at(4, 12'd1, 3, "winner_hold2");
    step();
    bus.game_over = 1'b0;
    bus.hcount    = 11'd256;
    bus.vcount    = 11'd300;
    step(); step();

    // Release: ARMED with blink_on cleared; 60 frames toggle at 30 and 60
    bus.key_enter = 1'b0;
    for (int k = 0; k < 6; k++) step();
    blink_exp = 1'b0;
    for (int f = 1; f <= 60; f++) begin
      blink_prev = blink_exp;
      if (f % 30 == 0) blink_exp = ~blink_exp;
      bus.frame_start = 1'b1;
      exp_at(1, {11'd0, blink_prev}, 2, "blink_text_en_pre");
      exp_at(1, {11'd0, blink_exp}, 3, "blink_text_en_post");
      step();
      bus.frame_start = 1'b0;
      step();
    end

    // key_rise coincident with frame_start in ARMED: restart wins
    bus.key_enter = 1'b1;
    expect_restart_pulse();
    exp_at(1, 12'd1, 5, "text_en_restart");
    exp_at(1, 12'd0, 6, "text_en_play");
    step(); step();
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    for (int k = 0; k < 5; k++) step();
    bus.key_enter = 1'b0;
    for (int k = 0; k < 4; k++) step();

    // Reset asserted during RESTART
    bus.game_over = 1'b1;
    bus.tom_won   = 1'b1;
    exp_at(4, 12'd1, 1, "winner_tom2");
    step();
    bus.game_over = 1'b0;
    step();
    bus.key_enter = 1'b1;
    exp_at(5, 12'd0, 1, "pre_restart1");
    exp_at(5, 12'd0, 2, "pre_restart2");
    exp_at(6, 12'd1, 2, "busy_armed");
    step(); step(); step();
    rst_n = 1'b0;
    exp_at(5, 12'd0, 0, "restart_async_clr");
    exp_at(6, 12'd0, 0, "busy_async_clr");
    exp_at(4, 12'd0, 0, "winner_async_clr");
    exp_at(0, 12'd0, 0, "char_xy_async_clr");
    step(); step();
    rst_n = 1'b1;
    for (int unsigned k = 1; k <= 8; k++) begin
      exp_at(5, 12'd0, k, "no_restart_after_rst");
      exp_at(6, 12'd0, k, "busy_after_rst");
    end
    for (int k = 0; k < 5; k++) step();
    bus.key_enter = 1'b0;

    // Drain the scoreboard within a bounded number of cycles
    for (int k = 0; k < 20 && sb.size() != 0; k++) step();
    if (sb.size() != 0) begin
      $display("FAIL drain: got %0d pending expected 0", sb.size());
      errors += int'(sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
